vend_controller: RTL and testbench
==================================

# vend_controller

Sequencing controller for the vending machine's 4-bit credit register. Accepts coin events, accumulates credit in nickel units, dispenses one item at a fixed price, and returns change or refunds on cancel through a held/acknowledged change interface. Sits between the coin acceptor front end and the dispense/change actuators and owns the only write path into the credit register.

## Interface
- PRICE, default 5, item price in nickel units (5 = 25c); legal range 1..15
- CLK  in  1  system clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset; 0 clears all state immediately
- coin_valid  in  1  one-cycle coin event strobe
- coin_type  in  2  00 nickel (1), 01 dime (2), 10 quarter (5), 11 slug (invalid)
- vend_req  in  1  request to purchase, sampled each cycle
- cancel  in  1  request refund of all credit
- change_ack  in  1  change actuator has taken change_units
- credit  out  4  current credit in nickel units
- dispense  out  1  one-cycle dispense pulse
- change_valid  out  1  change amount presented, held until acknowledged
- change_units  out  4  change/refund amount, valid while change_valid
- coin_reject  out  1  one-cycle pulse: coin returned, not credited
- busy  out  1  high in VEND and CHANGE

## Operation
- States: IDLE (credit 0), ACCUM (credit > 0), VEND, CHANGE. Encoding via shared package enum.
- Coin value: nickel 1, dime 2, quarter 5, slug 0 -> always rejected.
- IDLE/ACCUM, priority cancel > vend_req > coin_valid:
  - cancel with credit > 0 -> CHANGE, change_units = credit; cancel with credit 0 ignored.
  - vend_req with credit >= PRICE -> VEND, credit <= credit - PRICE. vend_req with credit < PRICE ignored, no state change.
  - coin_valid alone: if credit + value <= 15, credit += value, state -> ACCUM; else coin_reject, credit unchanged (no 4-bit wrap ever).
  - coin_valid in same cycle as an accepted cancel or vend_req -> coin_reject.
- VEND: exactly one cycle, dispense = 1. Next: CHANGE if credit > 0, else IDLE.
- CHANGE: change_valid = 1, change_units = credit, both stable until change_ack. On change_ack: credit <= 0, -> IDLE. change_ack outside CHANGE ignored.
- VEND/CHANGE: any coin_valid -> coin_reject; vend_req and cancel ignored.
- Arithmetic: 5-bit internal sum for overflow check; credit stored 4 bits.

## Timing
- All outputs registered. Reset values: credit 0, dispense 0, change_valid 0, change_units 0, coin_reject 0, busy 0, state IDLE.
- Coin accepted at edge N -> credit reflects it from cycle N+1.
- vend_req sampled at edge N -> dispense high for cycle N+1, credit shows remainder in N+1; change_valid high from N+2 if remainder > 0.
- cancel at edge N -> change_valid high from N+1.
- change_ack at edge M -> change_valid low and credit 0 from M+1; earliest next coin accepted at edge M+1.
- coin_reject asserted cycle after offending coin_valid, one cycle wide.
- RESET low mid-VEND/CHANGE: dispense and change_valid drop asynchronously, pending change discarded, credit 0.

## Structure
- Package vend_pkg: state enum, coin_type encodings, coin value function, MAX_CREDIT = 15, CREDIT_W = 4.
- Sub-module credit_reg: 4-bit register of per-bit DFFs with async active-low clear and load enable; controller drives its D/enable, reads Q as credit.
- Controller: next-state/next-credit combinational block plus registered outputs.

## Test plan
- Reset: RESET low during random inputs -> all outputs 0; release, quarter -> credit 5 next cycle.
- Exact vend, PRICE 5: quarter, vend_req -> dispense one cycle, credit 0, IDLE, change_valid never asserted.
- Change: quarter + dime (credit 7), vend_req -> dispense, then change_valid=1, change_units=2 held 3 cycles until change_ack -> credit 0.
- Overflow: three quarters (15), nickel -> coin_reject, credit stays 15; slug in IDLE -> coin_reject, credit 0.
- Priority/collision: credit 6, cancel+vend_req+dime same cycle -> CHANGE with change_units 6, coin_reject, no dispense; vend_req with credit 3 -> ignored.
- Reset mid-CHANGE: change_valid high, RESET low -> change_valid 0 asynchronously, credit 0, IDLE after release.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared types, widths and coin valuation for the vending controller.
package vend_pkg;
    localparam int CREDIT_W   = 4;
    localparam int MAX_CREDIT = 15;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_VEND, S_CHANGE} state_e;

    typedef enum logic [1:0] {
        COIN_NICKEL  = 2'b00,
        COIN_DIME    = 2'b01,
        COIN_QUARTER = 2'b10,
        COIN_SLUG    = 2'b11
    } coin_e;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] t);
        return t == COIN_NICKEL  ? 4'd1 :
               t == COIN_DIME    ? 4'd2 :
               t == COIN_QUARTER ? 4'd5 : 4'd0;
    endfunction
endpackage

// File: rtl/vend_controller_credit_reg.sv
// credit_reg: credit storage as per-bit DFFs with async active-low clear and load enable.
module credit_reg
    import vend_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [CREDIT_W-1:0] d_i,
    output logic [CREDIT_W-1:0] q_o
);
    for (genvar i = 0; i < CREDIT_W; i++) begin : g_bit
        logic bit_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) bit_q <= 1'b0;
            else if (en_i) bit_q <= d_i[i];
        end
        assign q_o[i] = bit_q;
    end
endmodule

// File: rtl/vend_controller.sv
// vend_controller: coin accumulation, single-price vend and held/acknowledged change return.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE = 5
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                vend_req,
    input  logic                cancel,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_units,
    output logic                coin_reject,
    output logic                busy
);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_d, change_units_q, change_units_d, value;
    logic [CREDIT_W:0]   sum;
    logic                credit_en, dispense_q, dispense_d, change_valid_q, change_valid_d;
    logic                coin_reject_q, coin_reject_d, busy_q, busy_d;

    credit_reg u_credit (
        .clk_i (CLK),
        .rst_ni(RESET),
        .en_i  (credit_en),
        .d_i   (credit_d),
        .q_o   (credit)
    );

    assign value = coin_value(coin_type);
    // Fifth bit exposes overflow so credit never wraps past 15.
    assign sum   = {1'b0, credit} + {1'b0, value};

    always_comb begin
        state_d        = state_q;
        credit_d       = credit;
        credit_en      = 1'b0;
        dispense_d     = 1'b0;
        change_valid_d = change_valid_q;
        change_units_d = change_units_q;
        coin_reject_d  = 1'b0;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (cancel && credit != '0) begin
                    state_d        = S_CHANGE;
                    change_valid_d = 1'b1;
                    change_units_d = credit;
                    coin_reject_d  = coin_valid;
                end else if (vend_req && credit >= PRICE_C) begin
                    state_d       = S_VEND;
                    credit_d      = credit - PRICE_C;
                    credit_en     = 1'b1;
                    dispense_d    = 1'b1;
                    coin_reject_d = coin_valid;
                end else if (coin_valid) begin
                    if (value != '0 && !sum[CREDIT_W]) begin
                        state_d   = S_ACCUM;
                        credit_d  = sum[CREDIT_W-1:0];
                        credit_en = 1'b1;
                    end else coin_reject_d = 1'b1;
                end
            end
            S_VEND: begin
                coin_reject_d  = coin_valid;
                state_d        = credit != '0 ? S_CHANGE : S_IDLE;
                change_valid_d = credit != '0;
                change_units_d = credit;
            end
            default: begin
                coin_reject_d = coin_valid;
                if (change_ack) begin
                    state_d        = S_IDLE;
                    credit_d       = '0;
                    credit_en      = 1'b1;
                    change_valid_d = 1'b0;
                    change_units_d = '0;
                end
            end
        endcase
        busy_d = state_d == S_VEND || state_d == S_CHANGE;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q        <= S_IDLE;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            change_units_q <= '0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            dispense_q     <= dispense_d;
            change_valid_q <= change_valid_d;
            change_units_q <= change_units_d;
            coin_reject_q  <= coin_reject_d;
            busy_q         <= busy_d;
        end
    end

    assign dispense     = dispense_q;
    assign change_valid = change_valid_q;
    assign change_units = change_units_q;
    assign coin_reject  = coin_reject_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed scenario tests with hand-computed expectations.
module tb_vend_controller;
    logic       CLK = 1'b0, RESET = 1'b0;
    logic       coin_valid = 1'b0, vend_req = 1'b0, cancel = 1'b0, change_ack = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic [3:0] credit, change_units;
    logic       dispense, change_valid, coin_reject, busy;
    int         errors = 0, checks = 0;

    vend_controller #(.PRICE(5)) dut (
        .CLK(CLK), .RESET(RESET), .coin_valid(coin_valid), .coin_type(coin_type),
        .vend_req(vend_req), .cancel(cancel), .change_ack(change_ack),
        .credit(credit), .dispense(dispense), .change_valid(change_valid),
        .change_units(change_units), .coin_reject(coin_reject), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        cycle();
        coin_valid = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        #2;
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            {coin_valid, vend_req, cancel, change_ack} = 4'($urandom);
            coin_type = 2'($urandom);
            cycle();
            checks++; if ({credit, dispense, change_valid, change_units, coin_reject, busy} !== 12'h0) begin errors++; $display("FAIL reset_outputs got %h exp 000", {credit, dispense, change_valid, change_units, coin_reject, busy}); end
        end
        {coin_valid, vend_req, cancel, change_ack} = 4'b0;
        RESET = 1'b1;
        coin(2'b10);
        checks++; if (credit !== 4'd5) begin errors++; $display("FAIL reset_quarter credit got %0d exp 5", credit); end
        checks++; if (busy !== 1'b0 || coin_reject !== 1'b0) begin errors++; $display("FAIL reset_quarter busy/reject got %b%b exp 00", busy, coin_reject); end
    endtask

    task automatic test_exact_vend();
        do_reset();
        coin(2'b10);
        vend_req = 1'b1;
        cycle();
        vend_req = 1'b0;
        checks++; if (dispense !== 1'b1 || credit !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL exact_vend got disp=%b credit=%0d busy=%b exp 1 0 1", dispense, credit, busy); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (dispense !== 1'b0 || change_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL exact_vend_after got disp=%b cv=%b busy=%b exp 0 0 0", dispense, change_valid, busy); end
        end
    endtask

    task automatic test_change();
        do_reset();
        coin(2'b10);
        coin(2'b01);
        checks++; if (credit !== 4'd7) begin errors++; $display("FAIL change_credit got %0d exp 7", credit); end
        vend_req = 1'b1;
        cycle();
        vend_req = 1'b0;
        checks++; if (dispense !== 1'b1 || credit !== 4'd2 || change_valid !== 1'b0) begin errors++; $display("FAIL change_vend got disp=%b credit=%0d cv=%b exp 1 2 0", dispense, credit, change_valid); end
        cycle();
        checks++; if (change_valid !== 1'b1 || change_units !== 4'd2 || dispense !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL change_present got cv=%b units=%0d disp=%b busy=%b exp 1 2 0 1", change_valid, change_units, dispense, busy); end
        coin(2'b00);
        checks++; if (coin_reject !== 1'b1 || credit !== 4'd2) begin errors++; $display("FAIL change_coin_reject got rej=%b credit=%0d exp 1 2", coin_reject, credit); end
        cycle();
        cycle();
        checks++; if (change_valid !== 1'b1 || change_units !== 4'd2 || coin_reject !== 1'b0) begin errors++; $display("FAIL change_hold got cv=%b units=%0d rej=%b exp 1 2 0", change_valid, change_units, coin_reject); end
        change_ack = 1'b1;
        cycle();
        change_ack = 1'b0;
        checks++; if (change_valid !== 1'b0 || credit !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL change_ack got cv=%b credit=%0d busy=%b exp 0 0 0", change_valid, credit, busy); end
        coin(2'b00);
        checks++; if (credit !== 4'd1 || coin_reject !== 1'b0) begin errors++; $display("FAIL change_next_coin got credit=%0d rej=%b exp 1 0", credit, coin_reject); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 3; i++) coin(2'b10);
        checks++; if (credit !== 4'd15) begin errors++; $display("FAIL overflow_fill got %0d exp 15", credit); end
        coin(2'b00);
        checks++; if (coin_reject !== 1'b1 || credit !== 4'd15) begin errors++; $display("FAIL overflow_nickel got rej=%b credit=%0d exp 1 15", coin_reject, credit); end
        cycle();
        checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL overflow_pulse got %b exp 0", coin_reject); end
        do_reset();
        coin(2'b11);
        checks++; if (coin_reject !== 1'b1 || credit !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL slug got rej=%b credit=%0d busy=%b exp 1 0 0", coin_reject, credit, busy); end
    endtask

    task automatic test_priority();
        do_reset();
        coin(2'b10);
        coin(2'b00);
        {cancel, vend_req, coin_valid} = 3'b111;
        coin_type = 2'b01;
        cycle();
        {cancel, vend_req, coin_valid} = 3'b000;
        checks++; if (change_valid !== 1'b1 || change_units !== 4'd6 || coin_reject !== 1'b1 || dispense !== 1'b0) begin errors++; $display("FAIL priority got cv=%b units=%0d rej=%b disp=%b exp 1 6 1 0", change_valid, change_units, coin_reject, dispense); end
        change_ack = 1'b1;
        cycle();
        change_ack = 1'b0;
        checks++; if (credit !== 4'd0 || change_valid !== 1'b0) begin errors++; $display("FAIL priority_ack got credit=%0d cv=%b exp 0 0", credit, change_valid); end
        do_reset();
        coin(2'b01);
        coin(2'b00);
        vend_req = 1'b1;
        cycle();
        vend_req = 1'b0;
        checks++; if (dispense !== 1'b0 || credit !== 4'd3 || busy !== 1'b0) begin errors++; $display("FAIL short_vend got disp=%b credit=%0d busy=%b exp 0 3 0", dispense, credit, busy); end
    endtask

    task automatic test_reset_mid_change();
        do_reset();
        coin(2'b10);
        cancel = 1'b1;
        cycle();
        cancel = 1'b0;
        checks++; if (change_valid !== 1'b1 || change_units !== 4'd5) begin errors++; $display("FAIL mid_cancel got cv=%b units=%0d exp 1 5", change_valid, change_units); end
        #2 RESET = 1'b0;
        #1;
        checks++; if (change_valid !== 1'b0 || credit !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_change_async got cv=%b credit=%0d busy=%b exp 0 0 0", change_valid, credit, busy); end
        RESET = 1'b1;
        cycle();
        checks++; if (change_valid !== 1'b0 || busy !== 1'b0 || change_units !== 4'd0) begin errors++; $display("FAIL mid_change_release got cv=%b busy=%b units=%0d exp 0 0 0", change_valid, busy, change_units); end
        coin(2'b10);
        vend_req = 1'b1;
        cycle();
        vend_req = 1'b0;
        #2 RESET = 1'b0;
        #1;
        checks++; if (dispense !== 1'b0 || credit !== 4'd0) begin errors++; $display("FAIL mid_vend_async got disp=%b credit=%0d exp 0 0", dispense, credit); end
        RESET = 1'b1;
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_change();
        test_overflow();
        test_priority();
        test_reset_mid_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
